// File: rtl/mem_block_arbiter.sv
// Round-robin block-transfer arbiter: two L2 requesters share one memory
// word port; each grant streams a whole block as single-word accesses.
module mem_block_arbiter #(
   parameter int n           = 32,
   parameter int BLOCK_WORDS = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              c0_req,
   input  logic                              c1_req,
   input  logic                              c0_we,
   input  logic                              c1_we,
   input  logic [15-$clog2(BLOCK_WORDS)-1:0] c0_block_addr,
   input  logic [15-$clog2(BLOCK_WORDS)-1:0] c1_block_addr,
   input  logic [n-1:0]                      c0_wdata,
   input  logic [n-1:0]                      c1_wdata,
   output logic                              c0_gnt,
   output logic                              c1_gnt,
   output logic                              c0_rvalid,
   output logic                              c1_rvalid,
   output logic                              c0_done,
   output logic                              c1_done,
   output logic [$clog2(BLOCK_WORDS)-1:0]    word_idx,
   output logic [$clog2(BLOCK_WORDS)-1:0]    rword_idx,
   output logic [n-1:0]                      rdata,
   output logic [14:0]                       L2_word_address,
   output logic                              L2_read_request,
   output logic                              L2_write_request,
   output logic [n-1:0]                      L2_wdata,
   input  logic [n-1:0]                      L2_rdata
);

   localparam int OFF_W = $clog2(BLOCK_WORDS);
   localparam int BA_W  = 15 - OFF_W;
   localparam logic [OFF_W-1:0] CNT_MAX = OFF_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            r_state;
   logic              r_owner;
   logic              r_we;
   logic [BA_W-1:0]   r_addr;
   logic [OFF_W-1:0]  r_cnt;
   logic              r_last;
   logic              r_rv;
   logic [OFF_W-1:0]  r_rv_idx;

   state_t            w_state_nxt;
   logic              w_owner_nxt;
   logic              w_we_nxt;
   logic [BA_W-1:0]   w_addr_nxt;
   logic [OFF_W-1:0]  w_cnt_nxt;
   logic              w_last_nxt;
   logic              w_pick;
   logic              w_xfer;
   logic              w_busy;
   logic              w_done;
   logic              w_rd;
   logic              w_wr;

   // On a tie the requester not granted last wins; otherwise whoever asks.
   assign w_pick = (c0_req & c1_req) ? ~r_last : c1_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_owner  <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_cnt    <= '0;
         r_last   <= 1'b1;
         r_rv     <= 1'b0;
         r_rv_idx <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_we     <= w_we_nxt;
         r_addr   <= w_addr_nxt;
         r_cnt    <= w_cnt_nxt;
         r_last   <= w_last_nxt;
         r_rv     <= w_rd;
         r_rv_idx <= w_rd ? r_cnt : '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_we_nxt    = r_we;
      w_addr_nxt  = r_addr;
      w_cnt_nxt   = r_cnt;
      w_last_nxt  = r_last;
      unique case (r_state)
         S_IDLE: begin
            if (c0_req | c1_req) begin
               w_owner_nxt = w_pick;
               w_we_nxt    = w_pick ? c1_we : c0_we;
               w_addr_nxt  = w_pick ? c1_block_addr : c0_block_addr;
               w_cnt_nxt   = '0;
               w_last_nxt  = w_pick;
               w_state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == CNT_MAX) begin
               w_state_nxt = r_we ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_xfer = (r_state == S_XFER);
   assign w_busy = (r_state != S_IDLE);
   assign w_done = (r_state == S_DONE);
   assign w_rd   = w_xfer & ~r_we;
   assign w_wr   = w_xfer & r_we;

   assign c0_gnt    = w_busy & ~r_owner;
   assign c1_gnt    = w_busy & r_owner;
   assign c0_done   = w_done & ~r_owner;
   assign c1_done   = w_done & r_owner;
   assign c0_rvalid = r_rv & ~r_owner;
   assign c1_rvalid = r_rv & r_owner;

   assign word_idx  = r_cnt;
   assign rword_idx = r_rv_idx;
   // Memory read data is forwarded only in the cycle it belongs to a read.
   assign rdata     = r_rv ? L2_rdata : '0;

   assign L2_word_address  = w_xfer ? {r_addr, r_cnt} : '0;
   assign L2_read_request  = w_rd;
   assign L2_write_request = w_wr;
   assign L2_wdata = w_wr ? (r_owner ? c1_wdata : c0_wdata) : '0;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Bench for mem_block_arbiter: word-addressed memory model, directed
// block-transfer vectors and hand sequences for reset and fairness.
module tb_mem_block_arbiter;

   localparam int BW = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        c0_req, c1_req, c0_we, c1_we;
   logic [10:0] c0_block_addr, c1_block_addr;
   logic [31:0] c0_wdata, c1_wdata;
   logic        c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_done, c1_done;
   logic [3:0]  word_idx, rword_idx;
   logic [31:0] rdata;
   logic [14:0] L2_word_address;
   logic        L2_read_request, L2_write_request;
   logic [31:0] L2_wdata, L2_rdata;

   logic [31:0] wb0, wb1;
   logic [31:0] ram [0:32767];
   int          checks = 0;
   int          failures = 0;
   int          overlap = 0;

   typedef struct {
      logic        r0, r1, we0, we1;
      logic [10:0] a0, a1;
      logic [31:0] wb0, wb1;
      int          exp_own;
      logic [31:0] exp_base;
      int          exp_done;
   } vec_t;

   vec_t vecs [8];

   mem_block_arbiter dut (
      .clk(clk), .reset(reset),
      .c0_req(c0_req), .c1_req(c1_req),
      .c0_we(c0_we), .c1_we(c1_we),
      .c0_block_addr(c0_block_addr), .c1_block_addr(c1_block_addr),
      .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
      .c0_gnt(c0_gnt), .c1_gnt(c1_gnt),
      .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
      .c0_done(c0_done), .c1_done(c1_done),
      .word_idx(word_idx), .rword_idx(rword_idx), .rdata(rdata),
      .L2_word_address(L2_word_address),
      .L2_read_request(L2_read_request),
      .L2_write_request(L2_write_request),
      .L2_wdata(L2_wdata), .L2_rdata(L2_rdata)
   );

   always #5 clk = ~clk;

   assign c0_wdata = wb0 + 32'(word_idx);
   assign c1_wdata = wb1 + 32'(word_idx);

   always @(posedge clk) begin
      if (L2_write_request) ram[L2_word_address] <= L2_wdata;
      if (L2_read_request) L2_rdata <= ram[L2_word_address];
   end

   always @(negedge clk) begin
      if (L2_read_request && L2_write_request) overlap++;
      if (c0_gnt && c1_gnt) overlap++;
   end

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] outs();
      return 128'({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_done, c1_done,
                   word_idx, rword_idx, rdata, L2_word_address,
                   L2_read_request, L2_write_request, L2_wdata});
   endfunction

   task automatic do_xfer(input vec_t v, input int drop_at, input string nm);
      int wt, nrv, nwr, nrd, bad, other, ndone, done_d;
      bit got;
      logic own, we;
      logic [10:0] a;
      logic [31:0] wb;
      c0_req = v.r0; c1_req = v.r1; c0_we = v.we0; c1_we = v.we1;
      c0_block_addr = v.a0; c1_block_addr = v.a1;
      wb0 = v.wb0; wb1 = v.wb1;
      wt = 0; got = 0;
      while (!got && wt < 6) begin
         @(negedge clk);
         wt++;
         got = c0_gnt | c1_gnt;
      end
      own = c1_gnt;
      check({nm, "_owner"}, got ? 128'(own) : 128'd2, 128'(v.exp_own));
      if (!got) begin
         c0_req = 0; c1_req = 0;
         return;
      end
      a  = own ? v.a1 : v.a0;
      wb = own ? v.wb1 : v.wb0;
      we = own ? v.we1 : v.we0;
      nrv = 0; nwr = 0; nrd = 0; bad = 0; other = 0; ndone = 0;
      done_d = -1;
      for (int d = 0; d < 40 && done_d < 0; d++) begin
         if (d > 0) @(negedge clk);
         if (own ? !c1_gnt : !c0_gnt) bad++;
         if (own ? (c0_gnt | c0_rvalid | c0_done)
                 : (c1_gnt | c1_rvalid | c1_done)) other++;
         if (L2_write_request) begin
            if (L2_word_address !== {a, 4'(nwr)} ||
                L2_wdata !== wb + 32'(nwr)) bad++;
            nwr++;
         end
         if (L2_read_request) begin
            if (L2_word_address !== {a, 4'(nrd)}) bad++;
            nrd++;
         end
         if (own ? c1_rvalid : c0_rvalid) begin
            if (rword_idx !== 4'(nrv) ||
                rdata !== v.exp_base + 32'(nrv)) bad++;
            nrv++;
         end
         if (own ? c1_done : c0_done) begin
            ndone++;
            done_d = d;
            c0_req = 0; c1_req = 0;
         end
         if (d == drop_at) begin
            if (own) c1_req = 0;
            else c0_req = 0;
         end
      end
      for (int e = 0; e < 2; e++) begin
         @(negedge clk);
         if (c0_done | c1_done) ndone++;
         if (c0_gnt | c1_gnt) bad++;
      end
      check({nm, "_done_cyc"}, 128'(done_d), 128'(v.exp_done));
      check({nm, "_issued"}, 128'(we ? nwr : nrd), 128'(BW));
      check({nm, "_wrongkind"}, 128'(we ? nrd : nwr), 128'd0);
      check({nm, "_rvalid"}, 128'(nrv), we ? 128'd0 : 128'(BW));
      check({nm, "_bad"}, 128'(bad), 128'd0);
      check({nm, "_other"}, 128'(other), 128'd0);
      check({nm, "_ndone"}, 128'(ndone), 128'd1);
   endtask

   task automatic apply_reset();
      reset = 1;
      c0_req = 0; c1_req = 0;
      @(negedge clk);
      @(negedge clk);
      check("reset_outs", outs(), 128'd0);
      reset = 0;
   endtask

   task automatic starvation();
      int gap, cnt;
      bit got, fin;
      logic own;
      c0_we = 0; c1_we = 0;
      c0_block_addr = 11'h012; c1_block_addr = 11'h012;
      c0_req = 1; c1_req = 1;
      for (int g = 0; g < 4; g++) begin
         gap = 0; got = 0;
         while (!got && gap < 6) begin
            @(negedge clk);
            gap++;
            got = c0_gnt | c1_gnt;
            if (!got) begin
               c0_req = 1; c1_req = 1;
            end
         end
         own = c1_gnt;
         check($sformatf("starve_own%0d", g),
               got ? 128'(own) : 128'd2, 128'(g % 2));
         if (g > 0) check($sformatf("starve_gap%0d", g), 128'(gap), 128'd2);
         fin = 0; cnt = 0;
         while (!fin && cnt < 30) begin
            @(negedge clk);
            cnt++;
            if (own ? c1_done : c0_done) begin
               fin = 1;
               if (own) c1_req = 0;
               else c0_req = 0;
            end
         end
         check($sformatf("starve_done%0d", g), 128'(fin), 128'd1);
      end
      c0_req = 0; c1_req = 0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      // r0 r1 we0 we1 a0 a1 wb0 wb1 exp_own exp_base exp_done
      vecs[0] = '{1, 0, 1, 0, 11'h012, 11'h000, 32'hA000, 32'h0,
                  0, 32'h0, 16};
      vecs[1] = '{1, 0, 0, 0, 11'h012, 11'h000, 32'h0, 32'h0,
                  0, 32'hA000, 17};
      vecs[2] = '{0, 1, 0, 1, 11'h000, 11'h7FF, 32'h0, 32'hB0,
                  1, 32'h0, 16};
      vecs[3] = '{1, 0, 0, 0, 11'h7FF, 11'h000, 32'h0, 32'h0,
                  0, 32'hB0, 17};
      vecs[4] = '{1, 1, 0, 0, 11'h012, 11'h7FF, 32'h0, 32'h0,
                  1, 32'hB0, 17};
      vecs[5] = '{1, 1, 0, 0, 11'h012, 11'h7FF, 32'h0, 32'h0,
                  0, 32'hA000, 17};
      vecs[6] = '{1, 1, 1, 1, 11'h100, 11'h101, 32'hC00, 32'hD00,
                  1, 32'h0, 16};
      vecs[7] = '{1, 0, 0, 0, 11'h101, 11'h000, 32'h0, 32'h0,
                  0, 32'hD00, 17};

      c0_we = 0; c1_we = 0;
      c0_block_addr = 0; c1_block_addr = 0;
      wb0 = 0; wb1 = 0;
      apply_reset();

      for (int i = 0; i < 8; i++) begin
         do_xfer(vecs[i], -1, $sformatf("v%0d", i));
      end

      do_xfer(vecs[1], 5, "middrop");

      c0_we = 0; c0_block_addr = 11'h012; c0_req = 1;
      repeat (6) @(negedge clk);
      check("midxfer_busy", 128'({c0_gnt, L2_read_request}), 128'd3);
      apply_reset();
      do_xfer(vecs[1], -1, "after_rst");

      apply_reset();
      starvation();

      check("rw_overlap", 128'(overlap), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_block_arbiter.md
# mem_block_arbiter

Two-port block-transfer controller and round-robin arbiter in front of the shared `main_memory` in the two-core system. Each L2 cache issues one whole-block read (fill) or write (writeback) request. The arbiter grants one requester at a time and sequences the block as consecutive single-word accesses on the memory's word port. It returns read words with a valid strobe and signals completion with a one-cycle done pulse.

## Interface
- `n`, 32: data word width, matches `main_memory`.
- `BLOCK_WORDS`, 16: words per cache block; power of two, at least 2.
- `OFF_W`, $clog2(BLOCK_WORDS): word-offset width (derived, not overridden).
- `clk`  in  1  single clock; all logic updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `c0_req`, `c1_req`  in  1  block request from L2 cache 0 / 1. Held until that requester's done pulse.
- `c0_we`, `c1_we`  in  1  1 = block write, 0 = block read; stable while req is high.
- `c0_block_addr`, `c1_block_addr`  in  15-OFF_W  block address; stable while req is high.
- `c0_wdata`, `c1_wdata`  in  n  write word selected by `word_idx`, supplied combinationally.
- `c0_gnt`, `c1_gnt`  out  1  requester owns the memory; high from the first XFER cycle through its DONE cycle.
- `c0_rvalid`, `c1_rvalid`  out  1  `rdata` holds read word `rword_idx` for this requester in this cycle.
- `c0_done`, `c1_done`  out  1  one-cycle transfer-complete pulse.
- `word_idx`  out  OFF_W  word currently issued to memory.
- `rword_idx`  out  OFF_W  index of the word on `rdata`.
- `rdata`  out  n  read word forwarded from memory.
- `L2_word_address`  out  15  to memory: `{block_addr, word_idx}`.
- `L2_read_request`, `L2_write_request`  out  1  to memory; never both high.
- `L2_wdata`  out  n  to memory: the granted requester's wdata.
- `L2_rdata`  in  n  from memory; valid the cycle after a read request.

## Operation
- States: IDLE, XFER, DRAIN, DONE.
- **IDLE**
  - Samples requests only in this state.
  - If no request is pending, stays in IDLE.
  - If exactly one requester is high, grants it.
  - If both are high, grants the requester that was not granted last.
  - `last` resets to 1, so core 0 wins the first tie.
  - On a grant: latch owner, we and block_addr; set counter = 0; go to XFER; set `last` = owner.
- **XFER**
  - Each cycle issues word `counter`: `L2_word_address = {addr, counter}`.
  - Read: `L2_read_request` = 1. Write: `L2_write_request` = 1 and `L2_wdata` = owner wdata.
  - Counter increments each cycle.
  - At counter = BLOCK_WORDS-1: a read goes to DRAIN, a write goes to DONE.
- **DRAIN** (reads only): captures the final returning word; no memory request.
- **DONE**
  - Owner's done = 1 and gnt stays high; no memory request.
  - Next state is IDLE.
- Read return path:
  - A 1-cycle delayed copy of (issued-read, counter) drives `rvalid`/`rword_idx`.
  - `rdata` = `L2_rdata`, passed combinationally through a registered select.
- Non-owner outputs (gnt, rvalid, done) stay 0 throughout.
- Owner deasserting req mid-transfer is ignored; the block completes.
- A requester must drop req in the cycle after done, or it is re-arbitrated as a new request.
- Reset at any point, including mid-transfer:
  - Next state is IDLE; `last` = 1; the partial transfer is abandoned.
  - All outputs are 0, including `word_idx`, `rword_idx`, `rdata` select, `L2_word_address` and `L2_wdata`.

## Timing
- Let req be sampled high in IDLE at edge t (state changes at edge t). Cycles below are counted from edge t.
- Read block:
  - XFER occupies cycles t..t+BW-1.
  - Word k is requested in cycle t+k; rvalid for word k is in cycle t+k+1.
  - DRAIN is cycle t+BW; DONE is cycle t+BW+1.
  - Total occupancy is BW+2 cycles; IDLE resumes at t+BW+2.
- Write block:
  - XFER occupies cycles t..t+BW-1; DONE is cycle t+BW.
  - Total occupancy is BW+1 cycles.
- The earliest next grant is the edge ending the first IDLE cycle. There is one idle cycle between transfers.
- Outputs are registered (state, counter, owner), except the `L2_wdata` and `rdata` muxes.

## Test plan
- **Reset values.** Assert reset for 2 cycles during a read XFER → next cycle all outputs 0 and state IDLE. A following c0 read starts again at word 0.
- **Single read.**
  - Setup: preload ram[0x0120+k] = 0xA000+k; c0 read with block_addr 0x012 (BW=16).
  - Expect: c0_rvalid for 16 consecutive cycles with rword_idx 0..15 and rdata 0xA000..0xA00F.
  - Expect: c0_done exactly 1 cycle after the last rvalid; c1 outputs stay 0.
- **Single write.**
  - Setup: c1 write of block 0x7FF, with c1_wdata = 0xB0 + word_idx.
  - Expect: 16 write requests to addresses 0x7FF0..0x7FFF.
  - Expect: c1_done in the 17th cycle after grant.
  - Expect: a later read returns 0xB0..0xBF.
- **Simultaneous requests.**
  - Stimulus: c0 and c1 raise req in the same cycle after reset.
  - Expect: c0 granted first, then c1 granted after c0_done plus one IDLE cycle.
  - Repeat the tie: c1 is now not-last and wins, and the grants alternate.
- **Starvation check.** c0 re-requests immediately after each done while c1 holds req → grants alternate c0, c1, c0, c1; c1 waits at most one block.
- **Mid-transfer deassert.** c0 drops req during XFER word 5 → all 16 words are still issued, and done pulses once. `L2_read_request` and `L2_write_request` are never simultaneously high (assertion).
